// File: rtl/dds_reload_ctrl_pkg.sv
// Shared types and widths for the DDS reload sequencer: FSM encoding, parameter
// field widths and the pulse-repetition-interval helper.
package dds_reload_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CLEAR  = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam int W_WAVE = 6;
  localparam int W_MODE = 4;
  localparam int W_F    = 9;
  localparam int W_T    = 11;
  localparam int W_Z    = 7;
  localparam int W_PRI  = 18;

  // Repetition interval in ticks; Z of 0 or 1 degenerates to a 100% duty cycle.
  function automatic logic [W_PRI-1:0] pri_len(input logic [W_T-1:0] t,
                                               input logic [W_Z-1:0] z);
    logic [W_PRI-1:0] t_ext;
    logic [W_PRI-1:0] z_ext;
    t_ext = W_PRI'(t);
    z_ext = (z <= W_Z'(1)) ? W_PRI'(1) : W_PRI'(z);
    return t_ext * z_ext;
  endfunction

endpackage

// File: rtl/dds_reload_ctrl_tick_div.sv
// Time-unit prescaler: one-cycle tick in the restart cycle and every TICK_DIV
// cycles after it.
module dds_tick_div #(
  parameter int TICK_DIV = 50
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic restart,
  output logic tick
);

  localparam int W_DIV = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W_DIV-1:0] DIV_LAST = W_DIV'(TICK_DIV - 1);

  logic [W_DIV-1:0] div_cnt_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || restart || (div_cnt_reg == DIV_LAST)) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign tick = restart || (div_cnt_reg == DIV_LAST);

endmodule

// File: rtl/dds_reload_ctrl.sv
// Reload sequencer between the parameter change detector and the DDS datapath:
// settle, commit to shadow registers, clear the phase accumulator, then run.
module dds_reload_ctrl
  import dds_reload_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int CLR_CYC    = 4,
  parameter int TICK_DIV   = 50
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              param_chg,
  input  logic [W_WAVE-1:0] wave_sel,
  input  logic [W_MODE-1:0] mode_sel,
  input  logic [W_F-1:0]    F,
  input  logic [W_T-1:0]    T,
  input  logic [W_Z-1:0]    Z,
  output logic [W_WAVE-1:0] wave_sel_q,
  output logic [W_MODE-1:0] mode_sel_q,
  output logic [W_F-1:0]    F_q,
  output logic [W_T-1:0]    T_q,
  output logic [W_Z-1:0]    Z_q,
  output logic              phase_clr,
  output logic              dds_en,
  output logic              pulse_gate,
  output logic              frame_start,
  output logic              busy
);

  localparam int W_SET = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int W_CLR = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [W_SET-1:0] SETTLE_LAST = W_SET'(SETTLE_CYC - 1);
  localparam logic [W_CLR-1:0] CLR_LAST    = W_CLR'(CLR_CYC - 1);

  state_t             state_reg, state_next;
  logic [W_SET-1:0]   settle_cnt_reg, settle_cnt_next;
  logic [W_CLR-1:0]   clr_cnt_reg, clr_cnt_next;
  logic [W_PRI-1:0]   per_cnt_reg, per_cnt_next;
  logic               load_en;
  logic               run_enter;
  logic               tick;
  logic               fs_next;
  logic [W_PRI-1:0]   pri;
  logic [W_PRI-1:0]   per_inc;

  logic [W_WAVE-1:0]  wave_q_reg;
  logic [W_MODE-1:0]  mode_q_reg;
  logic [W_F-1:0]     f_q_reg;
  logic [W_T-1:0]     t_q_reg;
  logic [W_Z-1:0]     z_q_reg;
  logic               phase_clr_reg, dds_en_reg, pulse_gate_reg, frame_start_reg, busy_reg;

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    clr_cnt_next    = clr_cnt_reg;
    load_en         = 1'b0;
    case (state_reg)
      ST_SETTLE: begin
        if (param_chg) begin
          settle_cnt_next = '0;
        end else if (settle_cnt_reg == SETTLE_LAST) begin
          state_next      = ST_LOAD;
          settle_cnt_next = '0;
        end else begin
          settle_cnt_next = settle_cnt_reg + 1'b1;
        end
      end
      ST_LOAD: begin
        if (param_chg) begin
          state_next      = ST_SETTLE;
          settle_cnt_next = '0;
        end else begin
          load_en      = 1'b1;
          state_next   = ST_CLEAR;
          clr_cnt_next = '0;
        end
      end
      ST_CLEAR: begin
        if (param_chg) begin
          state_next      = ST_SETTLE;
          settle_cnt_next = '0;
        end else if (clr_cnt_reg == CLR_LAST) begin
          state_next = ST_RUN;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        if (param_chg) begin
          state_next      = ST_SETTLE;
          settle_cnt_next = '0;
        end
      end
      default: state_next = ST_SETTLE;
    endcase
  end

  assign run_enter = (state_next == ST_RUN) && (state_reg != ST_RUN);

  dds_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .restart (run_enter),
    .tick    (tick)
  );

  // Period count is evaluated one cycle ahead so the registered gates line up
  // with the first RUN cycle.
  assign pri     = pri_len(t_q_reg, z_q_reg);
  assign per_inc = per_cnt_reg + 1'b1;

  always_comb begin
    per_cnt_next = per_cnt_reg;
    fs_next      = 1'b0;
    if (run_enter) begin
      per_cnt_next = '0;
      fs_next      = 1'b1;
    end else if ((state_reg == ST_RUN) && tick) begin
      if (per_inc >= pri) begin
        per_cnt_next = '0;
        fs_next      = 1'b1;
      end else begin
        per_cnt_next = per_inc;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg       <= ST_SETTLE;
      settle_cnt_reg  <= '0;
      clr_cnt_reg     <= '0;
      per_cnt_reg     <= '0;
      wave_q_reg      <= '0;
      mode_q_reg      <= '0;
      f_q_reg         <= '0;
      t_q_reg         <= '0;
      z_q_reg         <= '0;
      phase_clr_reg   <= 1'b0;
      dds_en_reg      <= 1'b0;
      pulse_gate_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      busy_reg        <= 1'b1;
    end else begin
      state_reg       <= state_next;
      settle_cnt_reg  <= settle_cnt_next;
      clr_cnt_reg     <= clr_cnt_next;
      per_cnt_reg     <= per_cnt_next;
      if (load_en) begin
        wave_q_reg <= wave_sel;
        mode_q_reg <= mode_sel;
        f_q_reg    <= F;
        t_q_reg    <= T;
        z_q_reg    <= Z;
      end
      phase_clr_reg   <= (state_next == ST_CLEAR);
      dds_en_reg      <= (state_next == ST_RUN);
      busy_reg        <= (state_next != ST_RUN);
      pulse_gate_reg  <= (state_next == ST_RUN) && (per_cnt_next < W_PRI'(t_q_reg));
      frame_start_reg <= (state_next == ST_RUN) && fs_next && (t_q_reg != '0);
    end
  end

  assign wave_sel_q  = wave_q_reg;
  assign mode_sel_q  = mode_q_reg;
  assign F_q         = f_q_reg;
  assign T_q         = t_q_reg;
  assign Z_q         = z_q_reg;
  assign phase_clr   = phase_clr_reg;
  assign dds_en      = dds_en_reg;
  assign pulse_gate  = pulse_gate_reg;
  assign frame_start = frame_start_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_dds_reload_ctrl.sv
// Self-checking bench for dds_reload_ctrl: timing table, hand-written corner
// sequences and a randomized run against an elapsed-time reference model.
module tb_dds_reload_ctrl;

  localparam int SETTLE_CYC = 16;
  localparam int CLR_CYC    = 4;
  localparam int TICK_DIV   = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        param_chg = 1'b0;
  logic [5:0]  wave_sel = '0;
  logic [3:0]  mode_sel = '0;
  logic [8:0]  F = '0;
  logic [10:0] T = '0;
  logic [6:0]  Z = '0;
  logic [5:0]  wave_sel_q;
  logic [3:0]  mode_sel_q;
  logic [8:0]  F_q;
  logic [10:0] T_q;
  logic [6:0]  Z_q;
  logic        phase_clr, dds_en, pulse_gate, frame_start, busy;

  always #5 sys_clk = ~sys_clk;

  dds_reload_ctrl #(
    .SETTLE_CYC (SETTLE_CYC),
    .CLR_CYC    (CLR_CYC),
    .TICK_DIV   (TICK_DIV)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .param_chg   (param_chg),
    .wave_sel    (wave_sel),
    .mode_sel    (mode_sel),
    .F           (F),
    .T           (T),
    .Z           (Z),
    .wave_sel_q  (wave_sel_q),
    .mode_sel_q  (mode_sel_q),
    .F_q         (F_q),
    .T_q         (T_q),
    .Z_q         (Z_q),
    .phase_clr   (phase_clr),
    .dds_en      (dds_en),
    .pulse_gate  (pulse_gate),
    .frame_start (frame_start),
    .busy        (busy)
  );

  logic [4:0]  ctrl;
  logic [36:0] qs;
  logic [36:0] live;
  assign ctrl = {phase_clr, dds_en, pulse_gate, frame_start, busy};
  assign qs   = {wave_sel_q, mode_sel_q, F_q, T_q, Z_q};
  assign live = {wave_sel, mode_sel, F, T, Z};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model: 0=SETTLE 1=LOAD 2=CLEAR 3=RUN, counted in elapsed cycles.
  int          m_state = 0;
  int          m_free = 0;
  int          m_clr = 0;
  int          m_run = 0;
  logic [36:0] m_q = '0;

  task automatic model_adv();
    if (sys_rst) begin
      m_state = 0; m_free = 0; m_clr = 0; m_run = 0; m_q = '0;
    end else if (param_chg) begin
      m_state = 0; m_free = 0;
    end else begin
      case (m_state)
        0: begin
          m_free++;
          if (m_free == SETTLE_CYC) begin m_state = 1; m_free = 0; end
        end
        1: begin m_q = live; m_state = 2; m_clr = 0; end
        2: begin
          m_clr++;
          if (m_clr == CLR_CYC) begin m_state = 3; m_run = 0; end
        end
        default: m_run++;
      endcase
    end
  endtask

  function automatic logic [4:0] exp_ctrl();
    int t, z, pri;
    logic gate, fs;
    t = int'(m_q[17:7]);
    z = (int'(m_q[6:0]) <= 1) ? 1 : int'(m_q[6:0]);
    pri = t * z;
    gate = 1'b0;
    fs = 1'b0;
    if (m_state == 3 && t != 0) begin
      gate = ((m_run / TICK_DIV) % pri) < t;
      fs   = (m_run % (TICK_DIV * pri)) == 0;
    end
    return {m_state == 2, m_state == 3, gate, fs, m_state != 3};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_adv();
    #1;
    cyc++;
    chk("model_ctrl", 64'(ctrl), 64'(exp_ctrl()));
    chk("model_q", 64'(qs), 64'(m_q));
  endtask

  task automatic do_reset(input int n);
    sys_rst = 1'b1;
    param_chg = 1'b0;
    repeat (n) step();
    sys_rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_for(input bit want_en, input string name);
    int n;
    n = 0;
    while (((want_en ? dds_en : phase_clr) !== 1'b1) && n < 200) begin
      step();
      n++;
    end
    n_cmp++;
    if (n >= 200) begin
      n_bad++;
      $display("FAIL %s: got no assertion within 200 cycles, expected assertion", name);
    end
  endtask

  task automatic pulse_chg();
    param_chg = 1'b1;
    step();
    param_chg = 1'b0;
  endtask

  // Expected timing after reset release with T=3, Z=4, TICK_DIV=2.
  typedef struct {
    int         cyc;
    logic [4:0] ctrl;
    bit         loaded;
  } vec_t;
  vec_t tbl[13];

  task automatic run_table();
    logic [36:0] exp_q;
    exp_q = live;
    for (int i = 0; i < 13; i++) begin
      while (cyc < tbl[i].cyc) step();
      chk("tbl_ctrl", 64'(ctrl), 64'(tbl[i].ctrl));
      chk("tbl_q", 64'(qs), tbl[i].loaded ? 64'(exp_q) : 64'd0);
    end
  endtask

  initial begin
    int last_f, gate_cnt, fs_cnt, en_cnt;
    //            cyc  {clr,en,gate,fs,busy}  loaded
    tbl[0]  = '{0,  5'b00001, 1'b0};
    tbl[1]  = '{15, 5'b00001, 1'b0};
    tbl[2]  = '{16, 5'b00001, 1'b0};
    tbl[3]  = '{17, 5'b10001, 1'b1};
    tbl[4]  = '{20, 5'b10001, 1'b1};
    tbl[5]  = '{21, 5'b01110, 1'b1};
    tbl[6]  = '{22, 5'b01100, 1'b1};
    tbl[7]  = '{26, 5'b01100, 1'b1};
    tbl[8]  = '{27, 5'b01000, 1'b1};
    tbl[9]  = '{44, 5'b01000, 1'b1};
    tbl[10] = '{45, 5'b01110, 1'b1};
    tbl[11] = '{46, 5'b01100, 1'b1};
    tbl[12] = '{69, 5'b01110, 1'b1};

    wave_sel = 6'($urandom);
    mode_sel = 4'($urandom);
    F = 9'd10; T = 11'd3; Z = 7'd4;
    do_reset(3);
    chk("reset_ctrl", 64'(ctrl), 64'(5'b00001));
    chk("reset_q", 64'(qs), 64'd0);
    run_table();

    // Abort from RUN and recommit a new frequency word.
    F = 9'd25;
    pulse_chg();
    chk("abort_dds_en", 64'(dds_en), 64'd0);
    chk("abort_busy", 64'(busy), 64'd1);
    chk("abort_F_q", 64'(F_q), 64'd10);
    repeat (16) step();
    chk("load_F_q_old", 64'(F_q), 64'd10);
    step();
    chk("commit_F_q", 64'(F_q), 64'd25);
    chk("commit_clr", 64'(phase_clr), 64'd1);
    repeat (4) step();
    chk("rerun_en", 64'(dds_en), 64'd1);
    chk("rerun_fs", 64'(frame_start), 64'd1);
    repeat (30) step();

    // Change storm: a pulse every 10 cycles keeps the FSM settling.
    last_f = 0;
    for (int k = 0; k < 10; k++) begin
      F = 9'($urandom);
      last_f = int'(F);
      pulse_chg();
      chk("storm_F_q", 64'(F_q), 64'd25);
      repeat (9) step();
    end
    repeat (7) step();
    chk("storm_load_F_q", 64'(F_q), 64'd25);
    step();
    chk("storm_commit_F_q", 64'(F_q), 64'(last_f));

    // Abort in the second CLEAR cycle, then run with Z=0, T=5.
    T = 11'd5; Z = 7'd0;
    pulse_chg();
    wait_for(1'b0, "wait_clear");
    step();
    pulse_chg();
    chk("clr_abort_clr", 64'(phase_clr), 64'd0);
    chk("clr_abort_busy", 64'(busy), 64'd1);
    repeat (16) step();
    chk("clr_resettle_load", 64'(phase_clr), 64'd0);
    step();
    chk("clr_resettle_clr", 64'(phase_clr), 64'd1);
    repeat (4) step();
    chk("z0_run_en", 64'(dds_en), 64'd1);
    gate_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      gate_cnt += int'(pulse_gate);
      fs_cnt += int'(frame_start);
      step();
    end
    chk("z0_gate_cnt", 64'(gate_cnt), 64'd40);
    chk("z0_fs_cnt", 64'(fs_cnt), 64'd4);

    // T=0: DDS enabled but no pulses at all.
    T = 11'd0;
    pulse_chg();
    wait_for(1'b1, "wait_t0_run");
    gate_cnt = 0; fs_cnt = 0; en_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      gate_cnt += int'(pulse_gate);
      fs_cnt += int'(frame_start);
      en_cnt += int'(dds_en);
      step();
    end
    chk("t0_gate_cnt", 64'(gate_cnt), 64'd0);
    chk("t0_fs_cnt", 64'(fs_cnt), 64'd0);
    chk("t0_en_cnt", 64'(en_cnt), 64'd30);

    // Reset in the middle of a pulse, then the first-commit timing again.
    T = 11'd3; Z = 7'd4;
    pulse_chg();
    wait_for(1'b1, "wait_rst_run");
    step();
    chk("pre_rst_gate", 64'(pulse_gate), 64'd1);
    sys_rst = 1'b1;
    step();
    chk("midrst_q", 64'(qs), 64'd0);
    chk("midrst_ctrl", 64'(ctrl), 64'(5'b00001));
    do_reset(2);
    run_table();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      sys_rst = ($urandom_range(0, 499) == 0);
      param_chg = ($urandom_range(0, 119) == 0);
      if (param_chg || $urandom_range(0, 49) == 0) begin
        wave_sel = 6'($urandom);
        mode_sel = 4'($urandom);
        F = 9'($urandom);
        T = 11'($urandom_range(0, 5));
        Z = 7'($urandom_range(0, 4));
      end
      step();
    end
    sys_rst = 1'b0;
    param_chg = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
